// File: rtl/georam_rd_resp_if.sv
// ---------------------------------------------------------------------------
// georam_rd_resp_if
//  Byte-fetch channel between the GeoRAM read responder and the memory
//  arbiter. The responder raises MemReq with a stable MemAddr and holds both
//  until the arbiter returns a one-cycle MemAck, with the byte on MemRD in
//  that same cycle.
//
//  Signals
//   MemReq   1   fetch request (responder -> arbiter)
//   MemAddr  22  {Block, Window, A} byte address (responder -> arbiter)
//   MemAck   1   one-cycle completion pulse (arbiter -> responder)
//   MemRD    8   fetched byte, valid while MemAck=1 (arbiter -> responder)
//
//  Modports
//   master   responder side (drives request and address)
//   slave    arbiter side (drives acknowledge and data)
// ---------------------------------------------------------------------------
interface georam_rd_resp_if;
   logic        MemReq;
   logic [21:0] MemAddr;
   logic        MemAck;
   logic [7:0]  MemRD;

   modport master (
      output MemReq,
      output MemAddr,
      input  MemAck,
      input  MemRD
   );

   modport slave (
      input  MemReq,
      input  MemAddr,
      output MemAck,
      output MemRD
   );
endinterface

// File: rtl/georam_rd_resp.sv
// ---------------------------------------------------------------------------
// georam_rd_resp
//  Read-side responder for the GeoRAM-style expansion. Answers C64 reads of
//  the window page (IOSEL, $DExx) by fetching the addressed byte through the
//  memory arbiter, and reads of the register page (RegSEL, $DFC0-$DFFF) by
//  returning the current Block/Window registers directly.
//
//  Parameters
//   TIMEOUT  cycles to wait for MemAck before aborting a fetch (2..255)
//   FILL     byte returned after reset and on a fetch timeout
//
//  Ports
//   PHI2     in   1   sole clock, all state changes on posedge
//   RESET    in   1   synchronous reset, active-high
//   IOSEL    in   1   window page selected this cycle
//   RegSEL   in   1   register page selected this cycle
//   nWE      in   1   C64 R/W (high = read)
//   A        in   8   C64 A[7:0]
//   Block    in   8   current block register
//   Window   in   6   current window register
//   mem      if       fetch channel to the arbiter (master side)
//   RD       out  8   registered read data for the C64 bus
//   RDOE     out  1   drive RD onto the bus (combinational from the strobes)
//   Busy     out  1   a fetch is outstanding (state != IDLE)
//   TOErr    out  1   sticky fetch-timeout flag, cleared only by RESET
// ---------------------------------------------------------------------------
module georam_rd_resp #(
   parameter int         TIMEOUT = 8,
   parameter logic [7:0] FILL    = 8'hFF
) (
   input  logic                 PHI2,
   input  logic                 RESET,
   input  logic                 IOSEL,
   input  logic                 RegSEL,
   input  logic                 nWE,
   input  logic [7:0]           A,
   input  logic [7:0]           Block,
   input  logic [5:0]           Window,
   georam_rd_resp_if.master     mem,
   output logic [7:0]           RD,
   output logic                 RDOE,
   output logic                 Busy,
   output logic                 TOErr
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Terminal count of the MemAck wait; the counter holds the number of
   // REQ cycles already spent before the current one.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [1:0] state;
   logic [7:0] toCnt;
   logic       rdW;
   logic       rdR;

   // Register read-back: odd addresses return Block, even return Window.
   function automatic logic [7:0] regReadback(input logic       sel,
                                              input logic [7:0] blk,
                                              input logic [5:0] win);
      return sel ? blk : {2'b00, win};
   endfunction

   // Only the top 64 bytes of the register page ($DFC0-$DFFF) read back.
   assign rdW  = IOSEL & nWE;
   assign rdR  = RegSEL & nWE & A[7] & A[6];
   assign RDOE = rdW | rdR;
   assign Busy = (state != IDLE);

   always_ff @(posedge PHI2) begin
      if (RESET) begin
         state       <= IDLE;
         mem.MemReq  <= 1'b0;
         mem.MemAddr <= '0;
         RD          <= FILL;
         TOErr       <= 1'b0;
         toCnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               // MemAck here belongs to nothing of ours and is dropped.
               if (rdW) begin
                  mem.MemAddr <= {Block, Window, A};
                  mem.MemReq  <= 1'b1;
                  toCnt       <= '0;
                  state       <= REQ;
               end
            end

            REQ: begin
               // Address is frozen here: Block/Window edits and further
               // window reads do not disturb the fetch in flight.
               if (mem.MemAck) begin
                  RD         <= mem.MemRD;
                  mem.MemReq <= 1'b0;
                  state      <= DONE;
               end else if (toCnt == TO_LAST) begin
                  RD         <= FILL;
                  TOErr      <= 1'b1;
                  mem.MemReq <= 1'b0;
                  state      <= DONE;
               end else begin
                  toCnt <= toCnt + 8'd1;
               end
            end

            DONE: begin
               // Single settling cycle; reads arriving now are not queued.
               state <= IDLE;
            end

            default: begin
               mem.MemReq <= 1'b0;
               state      <= IDLE;
            end
         endcase

         // A register read-back takes RD over whatever the FSM chose this
         // cycle: the C64 is sampling the bus for that read right now.
         if (rdR) begin
            RD <= regReadback(A[0], Block, Window);
         end
      end
   end

endmodule
